// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's load/store port and the data-memory responder.
// master drives the request fields; slave returns data, ack, fault and busy.
interface dmem_responder_if;
    logic        in_req;
    logic        in_wr_en;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wr_data;
    logic [63:0] out_rd_data;
    logic        out_ack;
    logic        out_fault;
    logic        out_busy;

    modport master (
        output in_req, in_wr_en, in_size, in_unsigned, in_addr, in_wr_data,
        input  out_rd_data, out_ack, out_fault, out_busy
    );

    modport slave (
        input  in_req, in_wr_en, in_size, in_unsigned, in_addr, in_wr_data,
        output out_rd_data, out_ack, out_fault, out_busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word/dword load-store with lane select, extension and fault check.
// Latency: ack in cycle WAIT_CYCLES+1 after acceptance; one access per WAIT_CYCLES+2 cycles.
// Backpressure: single outstanding access; in_req is ignored whenever out_busy is high.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input logic             in_Clk,
    input logic             in_Rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, enter_resp;

    logic        wr_q, uns_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q;

    logic        op_wr, op_uns;
    logic [1:0]  op_size;
    logic [63:0] op_addr, op_wdata;
    logic [ADDR_WIDTH-1:0] op_row;
    logic [2:0]  op_off;
    logic        misalign, out_of_range, op_fault;

    logic [7:0]  size_lanes, lane_en;
    logic [63:0] row_rd, bit_mask, merged, shifted, ld_val;
    logic [63:0] rd_q;
    logic        fault_q;

    logic [63:0] mem [0:(1<<ADDR_WIDTH)-1];

    // With zero wait states the access completes on the accepting edge, so the
    // datapath works from the live request in IDLE and the latched copy otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            op_wr    = bus.in_wr_en;
            op_uns   = bus.in_unsigned;
            op_size  = bus.in_size;
            op_addr  = bus.in_addr;
            op_wdata = bus.in_wr_data;
        end else begin
            op_wr    = wr_q;
            op_uns   = uns_q;
            op_size  = size_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign op_row       = op_addr[ADDR_WIDTH+2:3];
    assign op_off       = op_addr[2:0];
    assign out_of_range = |(op_addr >> (ADDR_WIDTH + 3));
    assign op_fault     = misalign | out_of_range;
    assign row_rd       = mem[op_row];

    always_comb begin
        misalign   = 1'b0;
        size_lanes = 8'h01;
        case (op_size)
            2'd0: begin misalign = 1'b0;          size_lanes = 8'h01; end
            2'd1: begin misalign = op_addr[0];    size_lanes = 8'h03; end
            2'd2: begin misalign = |op_addr[1:0]; size_lanes = 8'h0F; end
            2'd3: begin misalign = |op_addr[2:0]; size_lanes = 8'hFF; end
        endcase
    end

    always_comb begin
        bit_mask = '0;
        lane_en  = size_lanes << op_off;
        for (int k = 0; k < 8; k++) begin
            bit_mask[8*k +: 8] = {8{lane_en[k]}};
        end
        merged  = (row_rd & ~bit_mask) | ((op_wdata << {op_off, 3'b000}) & bit_mask);
        shifted = row_rd >> {op_off, 3'b000};
        ld_val  = shifted;
        case (op_size)
            2'd0: ld_val = op_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1: ld_val = op_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: ld_val = op_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            2'd3: ld_val = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.in_wr_en;
                uns_q   <= bus.in_unsigned;
                size_q  <= bus.in_size;
                addr_q  <= bus.in_addr;
                wdata_q <= bus.in_wr_data;
            end
            if (enter_resp) begin
                rd_q    <= (op_wr || op_fault) ? 64'd0 : ld_val;
                fault_q <= op_fault;
            end else if (state_q == RESP) begin
                rd_q    <= '0;
                fault_q <= 1'b0;
            end
        end
    end

    // Array is not reset; a reset arriving before RESP must still suppress the store.
    always_ff @(posedge in_Clk) begin
        if (enter_resp && op_wr && !op_fault && !in_Rst) begin
            mem[op_row] <= merged;
        end
    end

    assign bus.out_ack     = (state_q == RESP);
    assign bus.out_busy    = (state_q != IDLE);
    assign bus.out_fault   = fault_q;
    assign bus.out_rd_data = rd_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 3 wait states) share request fields and are
// checked every cycle against a byte-addressed memory model, plus literal expectations per access.
module tb_dmem_responder;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  rst = 3'b111;
    logic        wr = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [63:0] addr = '0, wdata = '0;

    always #5 clk = ~clk;

    dmem_responder_if b0();
    dmem_responder_if b1();
    dmem_responder_if b2();

    assign b0.in_req = req[0]; assign b0.in_wr_en = wr; assign b0.in_size = size;
    assign b0.in_unsigned = uns; assign b0.in_addr = addr; assign b0.in_wr_data = wdata;
    assign b1.in_req = req[1]; assign b1.in_wr_en = wr; assign b1.in_size = size;
    assign b1.in_unsigned = uns; assign b1.in_addr = addr; assign b1.in_wr_data = wdata;
    assign b2.in_req = req[2]; assign b2.in_wr_en = wr; assign b2.in_size = size;
    assign b2.in_unsigned = uns; assign b2.in_addr = addr; assign b2.in_wr_data = wdata;

    logic        d_ack[3], d_fault[3], d_busy[3];
    logic [63:0] d_rd[3];
    assign d_ack[0] = b0.out_ack; assign d_fault[0] = b0.out_fault;
    assign d_busy[0] = b0.out_busy; assign d_rd[0] = b0.out_rd_data;
    assign d_ack[1] = b1.out_ack; assign d_fault[1] = b1.out_fault;
    assign d_busy[1] = b1.out_busy; assign d_rd[1] = b1.out_rd_data;
    assign d_ack[2] = b2.out_ack; assign d_fault[2] = b2.out_fault;
    assign d_busy[2] = b2.out_busy; assign d_rd[2] = b2.out_rd_data;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_w0 (.in_Clk(clk), .in_Rst(rst[0]), .bus(b0));
    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_w1 (.in_Clk(clk), .in_Rst(rst[1]), .bus(b1));
    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_w3 (.in_Clk(clk), .in_Rst(rst[2]), .bus(b2));

    int n_vec = 0, n_bad = 0;
    int e = 0;
    int lat_lit[3] = '{1, 2, 4};

    // Model state: one pending access per instance, memory as a byte map.
    bit          active[3];
    int          resp_edge[3];
    logic        p_wr[3], p_uns[3];
    logic [1:0]  p_size[3];
    logic [63:0] p_addr[3], p_wdata[3];
    logic [63:0] m_rd[3];
    logic        m_fault[3];
    logic [7:0]  mm [longint];

    logic [2:0]  seen = 3'b000;
    logic [63:0] last_rd[3];
    logic        last_fault[3];
    int          ack_edge[3];
    int          ack_cnt[3] = '{0, 0, 0};
    int          e_req;
    logic        x_ack, x_busy;
    logic [63:0] x_rd;

    function automatic int wc(int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    function automatic longint key(int i, logic [63:0] a);
        return (longint'(i) << 40) + longint'(a);
    endfunction

    function automatic void chk(string nm, int i, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h want %h", nm, i, got, exp);
        end
    endfunction

    function automatic void commit(int i);
        int nb;
        logic [63:0] v;
        nb = 1 << p_size[i];
        m_fault[i] = ((p_addr[i] % 64'(nb)) != 64'd0) || (p_addr[i] >= (64'd1 << (AW + 3)));
        m_rd[i] = '0;
        if (!m_fault[i]) begin
            if (p_wr[i]) begin
                for (int b = 0; b < nb; b++) mm[key(i, p_addr[i] + 64'(b))] = p_wdata[i][8*b +: 8];
            end else begin
                v = '0;
                for (int b = 0; b < nb; b++) v |= 64'(mm[key(i, p_addr[i] + 64'(b))]) << (8 * b);
                if (!p_uns[i] && nb != 8 && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
                m_rd[i] = v;
            end
        end
    endfunction

    always @(posedge clk) begin
        e = e + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) active[i] = 1'b0;
            else if (active[i]) begin
                if (e == resp_edge[i]) commit(i);
                else if (e == resp_edge[i] + 1) active[i] = 1'b0;
            end else if (req[i]) begin
                p_wr[i] = wr; p_uns[i] = uns; p_size[i] = size;
                p_addr[i] = addr; p_wdata[i] = wdata;
                resp_edge[i] = e + wc(i);
                active[i] = 1'b1;
                if (wc(i) == 0) commit(i);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            x_ack  = !rst[i] && active[i] && (e == resp_edge[i]);
            x_busy = !rst[i] && active[i];
            x_rd   = x_ack ? m_rd[i] : 64'd0;
            chk("ack_busy", i, {62'd0, d_ack[i], d_busy[i]}, {62'd0, x_ack, x_busy});
            chk("rd_data", i, d_rd[i], x_rd);
            if (x_ack) chk("fault", i, {63'd0, d_fault[i]}, {63'd0, m_fault[i]});
            if (d_ack[i] === 1'b1) begin
                seen[i] = 1'b1;
                last_rd[i] = d_rd[i];
                last_fault[i] = d_fault[i];
                ack_edge[i] = e;
                ack_cnt[i]++;
            end
        end
    end

    task automatic op(input string nm, input logic [2:0] m, input int hold, input logic w,
                      input logic [1:0] sz, input logic u, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] xr, input logic xf);
        @(posedge clk); #2;
        wr = w; size = sz; uns = u; addr = a; wdata = d;
        seen = 3'b000;
        e_req = e + 1;
        req = m;
        repeat (hold) @(posedge clk);
        #2 req = 3'b000;
        for (int t = 0; t < 40 && (seen & m) != m; t++) begin
            @(negedge clk); #1;
        end
        chk({nm, "_acked"}, 0, {61'd0, seen & m}, {61'd0, m});
        for (int i = 0; i < 3; i++) begin
            if (m[i] && seen[i]) begin
                chk({nm, "_latency"}, i, 64'(ack_edge[i] - e_req + 1), 64'(lat_lit[i]));
                chk({nm, "_rd"}, i, last_rd[i], xr);
                chk({nm, "_flt"}, i, {63'd0, last_fault[i]}, {63'd0, xf});
            end
        end
    endtask

    int cnt0;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 3'b000;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_flags", i, {61'd0, d_ack[i], d_fault[i], d_busy[i]}, 64'd0);
            chk("reset_rd", i, d_rd[i], 64'd0);
        end

        op("st10",   3'b111, 1, 1, 2'd3, 0, 64'h10,   64'h1122334455667788, 64'h0, 0);
        op("ld10",   3'b111, 1, 0, 2'd3, 0, 64'h10,   64'h0, 64'h1122334455667788, 0);
        op("stb13",  3'b111, 1, 1, 2'd0, 0, 64'h13,   64'hFFFFFFFFFFFFFFAB, 64'h0, 0);
        op("ld10b",  3'b111, 1, 0, 2'd3, 0, 64'h10,   64'h0, 64'h11223344AB667788, 0);
        op("stw14",  3'b111, 1, 1, 2'd2, 0, 64'h14,   64'h0000000012345678, 64'h0, 0);
        op("ld10c",  3'b111, 1, 0, 2'd3, 0, 64'h10,   64'h0, 64'h12345678AB667788, 0);
        op("ldh16",  3'b111, 1, 0, 2'd1, 0, 64'h16,   64'h0, 64'h0000000000001234, 0);
        op("st20",   3'b111, 1, 1, 2'd3, 0, 64'h20,   64'h000000008000FF80, 64'h0, 0);
        op("ldb20s", 3'b111, 1, 0, 2'd0, 0, 64'h20,   64'h0, 64'hFFFFFFFFFFFFFF80, 0);
        op("ldb20u", 3'b111, 1, 0, 2'd0, 1, 64'h20,   64'h0, 64'h0000000000000080, 0);
        op("ldw20s", 3'b111, 1, 0, 2'd2, 0, 64'h20,   64'h0, 64'hFFFFFFFF8000FF80, 0);
        op("ldh22s", 3'b111, 1, 0, 2'd1, 0, 64'h22,   64'h0, 64'hFFFFFFFFFFFF8000, 0);
        op("ldh22u", 3'b111, 1, 0, 2'd1, 1, 64'h22,   64'h0, 64'h0000000000008000, 0);
        op("ldd20u", 3'b111, 1, 0, 2'd3, 1, 64'h20,   64'h0, 64'h000000008000FF80, 0);
        op("ldh21",  3'b111, 1, 0, 2'd1, 0, 64'h21,   64'h0, 64'h0, 1);
        op("st00",   3'b111, 1, 1, 2'd3, 0, 64'h0,    64'hCAFEF00DDEADBEEF, 64'h0, 0);
        op("st2004", 3'b111, 1, 1, 2'd3, 0, 64'h2004, 64'h5555555555555555, 64'h0, 1);
        op("ld00",   3'b111, 1, 0, 2'd3, 0, 64'h0,    64'h0, 64'hCAFEF00DDEADBEEF, 0);
        op("ld2000", 3'b111, 1, 0, 2'd3, 0, 64'h2000, 64'h0, 64'h0, 1);
        op("stw1e",  3'b111, 1, 1, 2'd2, 0, 64'h1E,   64'h0, 64'h0, 1);

        // Request held high while busy: exactly one completion.
        cnt0 = ack_cnt[2];
        op("hold",   3'b100, 4, 0, 2'd3, 0, 64'h10,   64'h0, 64'h12345678AB667788, 0);
        repeat (4) @(posedge clk);
        chk("hold_one_ack", 2, 64'(ack_cnt[2] - cnt0), 64'd1);

        // Reset two cycles into a 3-wait-state store: store is dropped.
        op("st30",   3'b111, 1, 1, 2'd3, 0, 64'h30,   64'hA5A5000012345678, 64'h0, 0);
        cnt0 = ack_cnt[2];
        @(posedge clk); #2;
        wr = 1; size = 2'd3; uns = 0; addr = 64'h30; wdata = 64'hDEADDEADDEADDEAD;
        req = 3'b100;
        @(posedge clk); #2 req = 3'b000;
        @(posedge clk);
        @(posedge clk); #2 rst = 3'b100;
        @(negedge clk); #1;
        chk("rst_mid_flags", 2, {61'd0, d_ack[2], d_fault[2], d_busy[2]}, 64'd0);
        chk("rst_mid_rd", 2, d_rd[2], 64'd0);
        @(posedge clk); #2 rst = 3'b000;
        repeat (6) @(posedge clk);
        chk("rst_no_ack", 2, 64'(ack_cnt[2] - cnt0), 64'd0);
        op("ld30",   3'b100, 1, 0, 2'd3, 0, 64'h30,   64'h0, 64'hA5A5000012345678, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1);
    end
endmodule
